calib_seq: RTL and testbench
============================

# calib_seq

Calibration pulse sequencer that drives the calibration trigger datapath through a programmed run of charge-inject or external-pulse requests. It issues one single-clock CCB-style request at a time, waits for the returned calibration L1A (CAL_GTRG), enforces a programmable inter-pulse gap, and counts completed pulses. It sits between the JTAG configuration registers and the calibration trigger block, and replaces hand-issued CCB injects during calibration runs.

## Interface
- CNT_W, 8: width of pulse count NPULSE and PCNT.
- GAP_W, 12: width of inter-pulse gap GAP, in CLKCMS clocks.
- TMO, 512: timeout for CAL_GTRG return, in clocks; must be ≥ 2 and ≤ 2^GAP_W.

Ports:
- CLKCMS  in  1  40 MHz CMS clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-clock run request; accepted only in IDLE.
- ABORT  in  1  terminate the run; ignored in IDLE.
- HOLD  in  1  holdoff, e.g. DAQ busy; while high, no new request issues.
- MODE  in  2  0 = inject, 1 = pulse, 2 = alternate (inject first), 3 = inject.
- NPULSE  in  CNT_W  pulses per run.
- GAP  in  GAP_W  gap clocks after each L1A, minus 1.
- CAL_GTRG  in  1  calibration L1A returned from the trigger block, 1 clock wide.
- CCBINJ_REQ  out  1  single-clock inject request.
- CCBPLS_REQ  out  1  single-clock pulse request.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  single-clock end-of-run strobe.
- ERR  out  1  sticky timeout flag.
- PCNT  out  CNT_W  completed pulses in the current or last run.

## Operation
- States:
  - IDLE: START goes to ARM. START also latches MODE, NPULSE and GAP into shadow registers, clears PCNT and ERR, and sets the alternate toggle to inject.
  - ARM: goes to FIRE when HOLD = 0; otherwise stays in ARM.
  - FIRE: lasts exactly one clock, then WAIT_L1A. Asserts the selected request. In mode 2 the toggle flips after each FIRE.
  - WAIT_L1A: loads the timer with TMO-1.
    - CAL_GTRG = 1: PCNT += 1, then GAP.
    - Timer reaches 0 without CAL_GTRG: set ERR, go to DONE.
    - If CAL_GTRG and timer expiry occur in the same clock, CAL_GTRG wins.
  - GAP: loads the timer with the shadowed GAP and counts down. At 0, goes to DONE if PCNT == NPULSE, else to ARM.
  - DONE: DONE = 1 for one clock, then IDLE.
- If NPULSE = 0 at START, the path is IDLE → DONE with no request issued.
- ABORT in ARM, FIRE, WAIT_L1A or GAP goes to DONE on the next clock. ERR is unchanged and PCNT keeps its value. ABORT has priority over all other transitions.
- START while BUSY is ignored. CAL_GTRG outside WAIT_L1A is ignored (random and pedestal triggers).
- Changes to config inputs during a run have no effect; the shadows are used.
- PCNT saturates at 2^CNT_W - 1. This is unreachable because PCNT never exceeds NPULSE.
- Reset values: state IDLE; all outputs 0; PCNT 0; shadows 0.

## Timing
- All outputs are registered.
- START sampled at edge k: BUSY is high from edge k+1. With HOLD = 0, the request is high from edge k+2 to edge k+3.
- CAL_GTRG sampled at edge m: PCNT updates at edge m+1 and the GAP state begins at m+1. The next request rises at edge m+GAP+3.
- Timeout: ERR and state DONE at edge f+TMO+1, where f is the edge the request deasserts (entry to WAIT_L1A). DONE high for one clock, BUSY low one clock later.
- ABORT sampled at edge a: DONE high from edge a+1, BUSY low from edge a+2. A request is never cut short; it is always exactly one clock.
- HOLD is sampled only in ARM. HOLD rising during FIRE does not cancel the request.
- Reset assertion mid-run clears all outputs immediately (asynchronously). Deassertion is synchronised externally.

## Structure
- Package calib_seq_pkg:
  - State enum: IDLE, ARM, FIRE, WAIT_L1A, GAP, DONE.
  - MODE encodings.
  - Default widths.
- One sub-module, calib_seq_tmr: a loadable GAP_W-bit down-counter with load, enable and zero flag. It is shared between the timeout and gap intervals, which are mutually exclusive.

## Test plan
- MODE=0, NPULSE=3, GAP=9, CAL_GTRG returned 130 clocks after each request → 3 CCBINJ_REQ pulses and no CCBPLS_REQ. Each subsequent request rises 12 clocks after its CAL_GTRG. PCNT=3, one DONE, ERR=0.
- MODE=2, NPULSE=4 → request order INJ, PLS, INJ, PLS, each one clock wide. PCNT steps 1..4.
- MODE=1, NPULSE=5, CAL_GTRG never returned, TMO=512 → 1 request. ERR=1 and DONE 513 clocks after the request deasserts. PCNT=0.
- HOLD high for 40 clocks starting at START → first request delayed until 2 clocks after HOLD falls. A second START during the run is ignored.
- ABORT during GAP of pulse 2 of 6 → DONE next clock, PCNT=2, ERR=0. No further requests. Stray CAL_GTRG in IDLE leaves PCNT unchanged.
- RST_N low in WAIT_L1A → all outputs 0 immediately. After release, NPULSE=0 START gives DONE at k+1 with no request.

Source files
------------

// File: rtl/calib_seq_pkg.sv
// -----------------------------------------------------------------------------
// calib_seq_pkg
// Shared types and defaults for the calibration pulse sequencer.
//   state_t     : sequencer states
//   mode_t      : request-type selection (MODE input encoding)
//   DEF_*       : default parameter values for widths and timeout
//   fire_is_inj : picks inject vs. pulse for the next request
// -----------------------------------------------------------------------------
package calib_seq_pkg;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_GAP_W = 12;
   localparam int DEF_TMO   = 512;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_FIRE,
      ST_WAIT_L1A,
      ST_GAP,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_INJ   = 2'd0,
      MODE_PLS   = 2'd1,
      MODE_ALT   = 2'd2,
      MODE_INJ_B = 2'd3
   } mode_t;

   // alt_pls is the alternate toggle: 0 = next request is inject.
   function automatic logic fire_is_inj(input mode_t mode, input logic alt_pls);
      case (mode)
         MODE_PLS: return 1'b0;
         MODE_ALT: return !alt_pls;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/calib_seq_tmr.sv
// -----------------------------------------------------------------------------
// calib_seq_tmr
// Loadable down-counter shared by the L1A timeout and the inter-pulse gap.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   load  : load val (has priority over en)
//   en    : count down by one; holds at zero
//   val   : load value
//   zero  : counter is at zero
// -----------------------------------------------------------------------------
module calib_seq_tmr
   import calib_seq_pkg::*;
#(
   parameter int W = DEF_GAP_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/calib_seq.sv
// -----------------------------------------------------------------------------
// calib_seq
// Calibration pulse sequencer: issues NPULSE single-clock inject/pulse
// requests, waits for each returned CAL_GTRG, enforces a GAP+1 clock gap and
// counts completed pulses. Times out to ERR if CAL_GTRG never returns.
//   CLKCMS      : 40 MHz CMS clock
//   RST_N       : asynchronous active-low reset
//   START       : run request (IDLE only)      ABORT : end run early
//   HOLD        : holdoff for new requests      MODE  : request type select
//   NPULSE      : pulses per run                GAP   : gap clocks minus one
//   CAL_GTRG    : returned calibration L1A
//   CCBINJ_REQ  : inject request                CCBPLS_REQ : pulse request
//   BUSY        : run in progress               DONE  : end-of-run strobe
//   ERR         : sticky timeout flag           PCNT  : completed pulses
// All outputs are registered from the current state, so they trail the
// state register by one clock.
// -----------------------------------------------------------------------------
module calib_seq
   import calib_seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int GAP_W = DEF_GAP_W,
   parameter int TMO   = DEF_TMO
) (
   input  logic             CLKCMS,
   input  logic             RST_N,
   input  logic             START,
   input  logic             ABORT,
   input  logic             HOLD,
   input  logic [1:0]       MODE,
   input  logic [CNT_W-1:0] NPULSE,
   input  logic [GAP_W-1:0] GAP,
   input  logic             CAL_GTRG,
   output logic             CCBINJ_REQ,
   output logic             CCBPLS_REQ,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [CNT_W-1:0] PCNT
);

   localparam logic [GAP_W-1:0] TMO_LOAD = GAP_W'(TMO - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   mode_t            mode_sh;
   logic [CNT_W-1:0] npulse_sh;
   logic [GAP_W-1:0] gap_sh;
   logic             alt_pls;
   logic [CNT_W-1:0] cnt;
   logic             err_flag;

   logic             req_active;
   logic             tmr_load;
   logic             tmr_en;
   logic [GAP_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             tmo_hit;

   // The request is still on the wire during the first WAIT_L1A clock; the
   // timeout window is loaded then and starts when the request drops.
   assign req_active = CCBINJ_REQ | CCBPLS_REQ;
   assign tmo_hit    = (state == ST_WAIT_L1A) && !req_active && tmr_zero;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value held and no latch is inferred.
   always_comb begin
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_WAIT_L1A: begin
            if (CAL_GTRG) begin
               tmr_load = 1'b1;
               tmr_val  = gap_sh;
            end else if (req_active) begin
               tmr_load = 1'b1;
               tmr_val  = TMO_LOAD;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_GAP:  tmr_en = 1'b1;
         default: ;
      endcase
   end

   calib_seq_tmr #(.W(GAP_W)) u_tmr (
      .clk   (CLKCMS),
      .rst_n (RST_N),
      .load  (tmr_load),
      .en    (tmr_en),
      .val   (tmr_val),
      .zero  (tmr_zero)
   );

   always_ff @(posedge CLKCMS or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         mode_sh    <= MODE_INJ;
         npulse_sh  <= '0;
         gap_sh     <= '0;
         alt_pls    <= 1'b0;
         cnt        <= '0;
         err_flag   <= 1'b0;
         CCBINJ_REQ <= 1'b0;
         CCBPLS_REQ <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERR        <= 1'b0;
         PCNT       <= '0;
      end else begin
         CCBINJ_REQ <= (state == ST_FIRE) &&  fire_is_inj(mode_sh, alt_pls);
         CCBPLS_REQ <= (state == ST_FIRE) && !fire_is_inj(mode_sh, alt_pls);
         BUSY       <= (state != ST_IDLE);
         DONE       <= (state == ST_DONE);
         ERR        <= err_flag;
         PCNT       <= cnt;

         case (state)
            ST_IDLE: begin
               if (START) begin
                  mode_sh   <= mode_t'(MODE);
                  npulse_sh <= NPULSE;
                  gap_sh    <= GAP;
                  alt_pls   <= 1'b0;
                  cnt       <= '0;
                  err_flag  <= 1'b0;
                  state     <= (NPULSE == '0) ? ST_DONE : ST_ARM;
               end
            end
            ST_ARM: begin
               if (ABORT)      state <= ST_DONE;
               else if (!HOLD) state <= ST_FIRE;
            end
            ST_FIRE: begin
               if (mode_sh == MODE_ALT) alt_pls <= !alt_pls;
               state <= ABORT ? ST_DONE : ST_WAIT_L1A;
            end
            ST_WAIT_L1A: begin
               if (ABORT) begin
                  state <= ST_DONE;
               end else if (CAL_GTRG) begin
                  if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                  state <= ST_GAP;
               end else if (tmo_hit) begin
                  err_flag <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            ST_GAP: begin
               if (ABORT)         state <= ST_DONE;
               else if (tmr_zero) state <= (cnt == npulse_sh) ? ST_DONE : ST_ARM;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calib_seq.sv
// -----------------------------------------------------------------------------
// tb_calib_seq
// Self-checking bench for calib_seq. A CAL_GTRG responder returns the L1A a
// programmable number of clocks after each request; a monitor compares every
// request against a queue of expected request kinds. Edge numbers are taken
// from cyc, which counts rising edges; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_calib_seq;

   localparam int TMO = 512;
   localparam logic [1:0] KIND_INJ = 2'b10;
   localparam logic [1:0] KIND_PLS = 2'b01;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, hold, cal_gtrg;
   logic [1:0]  mode;
   logic [7:0]  npulse;
   logic [11:0] gap;
   logic        inj_req, pls_req, busy, done, err;
   logic [7:0]  pcnt;

   calib_seq #(.CNT_W(8), .GAP_W(12), .TMO(TMO)) dut (
      .CLKCMS     (clk),
      .RST_N      (rst_n),
      .START      (start),
      .ABORT      (abort),
      .HOLD       (hold),
      .MODE       (mode),
      .NPULSE     (npulse),
      .GAP        (gap),
      .CAL_GTRG   (cal_gtrg),
      .CCBINJ_REQ (inj_req),
      .CCBPLS_REQ (pls_req),
      .BUSY       (busy),
      .DONE       (done),
      .ERR        (err),
      .PCNT       (pcnt)
   );

   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard and logs: each queue has a single writer.
   logic [1:0] exp_q[$];     // written by main
   int         exp_rd = 0;   // monitor
   int         rise_q[$];    // monitor: edge at which each request rose
   int         pcnt_q[$];    // monitor: PCNT seen with each request
   int         gtrg_q[$];    // responder: edge at which each L1A is sampled
   int         done_cnt = 0; // monitor
   int         done_cyc = 0; // monitor
   int         gtrg_lat = 0; // main: 0 = never return the L1A
   int         stray_at = -1;// main: cycle for a stray CAL_GTRG

   // Monitor
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (inj_req || pls_req) begin
            rise_q.push_back(cyc);
            pcnt_q.push_back(int'(pcnt));
            if (prev_req) check("req_width", 32'(prev_req), 0);
            if (exp_rd < exp_q.size()) begin
               check("req_kind", 32'({inj_req, pls_req}), 32'(exp_q[exp_rd]));
               exp_rd++;
            end else begin
               check("req_unexpected", 32'({inj_req, pls_req}), 0);
            end
         end
         prev_req = inj_req || pls_req;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // CAL_GTRG responder
   initial begin
      logic pending;
      int   due;
      logic hit;
      pending  = 1'b0;
      due      = 0;
      cal_gtrg = 1'b0;
      forever begin
         @(negedge clk);
         if ((inj_req || pls_req) && gtrg_lat > 0) begin
            pending = 1'b1;
            due     = cyc + gtrg_lat - 1;
         end
         hit = pending && (cyc == due);
         if (hit) begin
            pending = 1'b0;
            gtrg_q.push_back(cyc + 1);
         end
         cal_gtrg = hit || (cyc == stray_at);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [1:0] exp_kind(input logic [1:0] m, input int i);
      if (m == 2'd1) return KIND_PLS;
      if (m == 2'd2) return (i % 2 == 0) ? KIND_INJ : KIND_PLS;
      return KIND_INJ;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Returns k, the edge at which START is sampled; ends at edge k+1.
   task automatic start_run(input logic [1:0] m, input int n, input int g, output int k);
      mode   = m;
      npulse = 8'(n);
      gap    = 12'(g);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      k      = cyc;
      check("busy_at_k", 32'(busy), 0);
      tick();
      check("busy_at_k1", 32'(busy), 1);
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick();
         n++;
      end
      check("done_seen", 32'(done_cnt - d0), 1);
   endtask

   typedef struct {
      logic [1:0] mode;
      int         npulse;
      int         gap;
      int         lat;          // CAL_GTRG return delay after request rise
      int         exp_pcnt;
      int         exp_l1a_req;  // L1A edge to next request rise
   } vec_t;

   vec_t vecs[4];

   initial begin
      int k, d0, rb, gb, h0, a;

      vecs[0] = '{mode: 2'd0, npulse: 3, gap: 9, lat: 130, exp_pcnt: 3, exp_l1a_req: 12};
      vecs[1] = '{mode: 2'd2, npulse: 4, gap: 2, lat: 5,   exp_pcnt: 4, exp_l1a_req: 5};
      vecs[2] = '{mode: 2'd1, npulse: 2, gap: 0, lat: 1,   exp_pcnt: 2, exp_l1a_req: 3};
      vecs[3] = '{mode: 2'd3, npulse: 2, gap: 4, lat: 3,   exp_pcnt: 2, exp_l1a_req: 7};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
      mode = '0; npulse = '0; gap = '0;
      repeat (3) tick();
      check("reset_outputs", 32'({inj_req, pls_req, busy, done, err, pcnt}), 0);
      rst_n = 1'b1;
      tick();

      // ---- table-driven normal runs ----
      for (int v = 0; v < 4; v++) begin
         d0 = done_cnt; rb = rise_q.size(); gb = gtrg_q.size();
         gtrg_lat = vecs[v].lat;
         for (int i = 0; i < vecs[v].npulse; i++) exp_q.push_back(exp_kind(vecs[v].mode, i));
         start_run(vecs[v].mode, vecs[v].npulse, vecs[v].gap, k);
         wait_done(d0, 3000);
         check("pcnt_final", 32'(pcnt), 32'(vecs[v].exp_pcnt));
         check("err_clear", 32'(err), 0);
         check("nreq", 32'(rise_q.size() - rb), 32'(vecs[v].npulse));
         check("start_to_req", 32'(rise_q[rb] - k), 2);
         for (int i = 1; i < vecs[v].npulse; i++)
            check("l1a_to_req", 32'(rise_q[rb+i] - gtrg_q[gb+i-1]), 32'(vecs[v].exp_l1a_req));
         for (int i = 0; i < vecs[v].npulse; i++)
            check("pcnt_at_req", 32'(pcnt_q[rb+i]), 32'(i));
         tick();
         check("done_width", 32'(done), 0);
         check("busy_after_done", 32'(busy), 0);
      end

      // ---- timeout: CAL_GTRG never returned ----
      d0 = done_cnt; rb = rise_q.size();
      gtrg_lat = 0;
      exp_q.push_back(KIND_PLS);
      start_run(2'd1, 5, 3, k);
      wait_done(d0, 1000);
      check("tmo_done_edge", 32'(done_cyc - (rise_q[rb] + 1)), 32'(TMO + 1));
      check("tmo_err", 32'(err), 1);
      check("tmo_pcnt", 32'(pcnt), 0);
      check("tmo_nreq", 32'(rise_q.size() - rb), 1);
      tick();
      check("tmo_busy_low", 32'(busy), 0);
      check("tmo_err_sticky", 32'(err), 1);

      // ---- HOLD for 40 clocks, second START ignored ----
      d0 = done_cnt; rb = rise_q.size(); gb = gtrg_q.size();
      gtrg_lat = 10;
      exp_q.push_back(KIND_INJ);
      exp_q.push_back(KIND_INJ);
      hold = 1'b1;
      start_run(2'd0, 2, 3, k);
      repeat (8) tick();
      mode = 2'd1; npulse = 8'd7; gap = 12'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < k + 39) tick();
      check("hold_blocks", 32'(rise_q.size() - rb), 0);
      hold = 1'b0;
      h0 = cyc;
      wait_done(d0, 500);
      check("hold_release_to_req", 32'(rise_q[rb] - h0), 2);
      check("hold_nreq", 32'(rise_q.size() - rb), 2);
      check("hold_pcnt", 32'(pcnt), 2);
      check("hold_err_cleared", 32'(err), 0);
      check("hold_gap", 32'(rise_q[rb+1] - gtrg_q[gb]), 6);
      tick();

      // ---- ABORT in the gap after pulse 2 of 6 ----
      d0 = done_cnt; rb = rise_q.size(); gb = gtrg_q.size();
      gtrg_lat = 4;
      exp_q.push_back(KIND_INJ);
      exp_q.push_back(KIND_INJ);
      start_run(2'd0, 6, 20, k);
      for (int n = 0; n < 500 && gtrg_q.size() < gb + 2; n++) tick();
      check("abort_l1a_seen", 32'(gtrg_q.size() - gb), 2);
      repeat (2) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      a = cyc;
      check("abort_no_early_done", 32'(done), 0);
      tick();
      check("abort_done_a1", 32'(done), 1);
      check("abort_pcnt", 32'(pcnt), 2);
      check("abort_err", 32'(err), 0);
      tick();
      check("abort_busy_a2", 32'(busy), 0);
      check("abort_one_done", 32'(done_cnt - d0), 1);
      repeat (40) tick();
      check("abort_no_more_req", 32'(rise_q.size() - rb), 2);
      stray_at = cyc + 1;
      repeat (3) tick();
      check("stray_l1a_pcnt", 32'(pcnt), 2);
      check("stray_l1a_busy", 32'(busy), 0);

      // ---- reset mid-run, then NPULSE = 0 ----
      rb = rise_q.size();
      gtrg_lat = 6;
      exp_q.push_back(KIND_INJ);
      exp_q.push_back(KIND_INJ);
      start_run(2'd0, 3, 2, k);
      for (int n = 0; n < 200 && rise_q.size() < rb + 2; n++) tick();
      repeat (2) tick();
      check("pcnt_before_rst", 32'(pcnt), 1);
      check("busy_before_rst", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_outputs", 32'({inj_req, pls_req, busy, done, err, pcnt}), 0);
      repeat (5) tick();
      rst_n = 1'b1;
      gtrg_lat = 0;
      tick();
      d0 = done_cnt; rb = rise_q.size();
      start_run(2'd0, 0, 0, k);
      check("npulse0_done_k1", 32'(done), 1);
      tick();
      check("npulse0_done_width", 32'(done), 0);
      check("npulse0_busy_low", 32'(busy), 0);
      repeat (10) tick();
      check("npulse0_no_req", 32'(rise_q.size() - rb), 0);
      check("npulse0_one_done", 32'(done_cnt - d0), 1);

      check("sb_drained", 32'(exp_rd), 32'(exp_q.size()));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
